// File: rtl/pwm_ramp_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_ramp_scheduler
//
// Soft-ramp duty-cycle controller placed in front of a PWM pulse generator.
// A ramp request (target duty + maximum step) is accepted over a valid/ready
// handshake. The duty output then moves toward the target by at most one step
// per PWM period. It changes only on the cycle after a period_tick, so the
// generator never sees a duty change in the middle of a period. A one-cycle
// done pulse marks arrival at the target.
//
// Optional feature macro: PWM_RAMP_RETARGET_EN
//   undefined (default) : requests are accepted only in IDLE.
//   defined             : requests are also accepted while ramping and replace
//                         the target/step without disturbing duty_out.
//
// Parameters
//   WIDTH       width of duty, target and step (matches the PWM counter)
//   RESET_DUTY  duty_out value after reset
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   period_tick  one-cycle pulse when the generator period counter wraps
//   req_valid    ramp request present
//   req_target   requested final duty
//   req_step     maximum duty change per period (0 = jump at next tick)
//   req_ready    request can be accepted this cycle (registered)
//   duty_out     registered duty value to the PWM generator
//   busy         high whenever the controller is not idle (registered)
//   done         one-cycle pulse once duty_out has reached the target
// -----------------------------------------------------------------------------
module pwm_ramp_scheduler #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DUTY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             period_tick,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] req_step,
  output logic             req_ready,
  output logic [WIDTH-1:0] duty_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

`ifdef PWM_RAMP_RETARGET_EN
  localparam logic RAMP_READY = 1'b1;
`else
  localparam logic RAMP_READY = 1'b0;
`endif

  state_t           state;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] step_q;

  logic             accept;
  logic [WIDTH-1:0] distance;
  logic [WIDTH-1:0] next_duty;
  logic [WIDTH-1:0] done_target;

  assign accept = req_valid && req_ready;

  // Candidate duty for the next period boundary. The distance to the target
  // is compared against the step before any add/subtract happens, so the
  // result always lands between duty_out and target_q and can never wrap
  // past 0 or 2^WIDTH-1.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    distance  = '0;
    next_duty = duty_out;
    if (step_q == '0) begin
      next_duty = target_q;
    end else if (target_q > duty_out) begin
      distance  = target_q - duty_out;
      next_duty = (distance <= step_q) ? target_q : duty_out + step_q;
    end else if (target_q < duty_out) begin
      distance  = duty_out - target_q;
      next_duty = (distance <= step_q) ? target_q : duty_out - step_q;
    end
  end

  // Target used for the arrival check. When a retarget is accepted in the
  // same cycle as a tick, that tick still steps toward the old target, but
  // completion is judged against the new one.
  always_comb begin
    done_target = target_q;
`ifdef PWM_RAMP_RETARGET_EN
    if (accept) begin
      done_target = req_target;
    end
`endif
  end

  // Single-process FSM; req_ready, busy and done are registered alongside the
  // state so they are glitch-free and exactly track the state they describe.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), and every
    // register including target_q/step_q gets a defined value, so a ramp
    // abandoned by reset leaves no stale request behind.
    if (rst) begin
      state     <= S_IDLE;
      target_q  <= RESET_DUTY;
      step_q    <= '0;
      duty_out  <= RESET_DUTY;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // A tick arriving together with the accept is deliberately
          // ignored; the first step waits for the following tick.
          if (accept) begin
            target_q  <= req_target;
            step_q    <= req_step;
            state     <= S_RAMP;
            busy      <= 1'b1;
            req_ready <= RAMP_READY;
          end
        end

        S_RAMP: begin
`ifdef PWM_RAMP_RETARGET_EN
          if (accept) begin
            target_q <= req_target;
            step_q   <= req_step;
          end
`endif
          if (period_tick) begin
            duty_out <= next_duty;
            if (next_duty == done_target) begin
              state     <= S_DONE;
              done      <= 1'b1;
              req_ready <= 1'b0;
            end
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_scheduler
//
// Self-checking bench for pwm_ramp_scheduler (WIDTH=8, RESET_DUTY=0).
// Expected duty sequences come from a ramp model that works on signed
// distances: each tick moves by the step, or lands on the target when the
// remaining distance fits within one step (or the step is 0).
// -----------------------------------------------------------------------------
module tb_pwm_ramp_scheduler;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             period_tick;
  logic             req_valid;
  logic [WIDTH-1:0] req_target;
  logic [WIDTH-1:0] req_step;
  logic             req_ready;
  logic [WIDTH-1:0] duty_out;
  logic             busy;
  logic             done;

  int vectors;
  int miscompares;
  int m_duty;  // bench's own record of the duty the DUT should be holding

`ifdef PWM_RAMP_RETARGET_EN
  localparam logic EXP_RAMP_READY = 1'b1;
`else
  localparam logic EXP_RAMP_READY = 1'b0;
`endif

  pwm_ramp_scheduler #(
    .WIDTH      (WIDTH),
    .RESET_DUTY (8'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .period_tick (period_tick),
    .req_valid   (req_valid),
    .req_target  (req_target),
    .req_step    (req_step),
    .req_ready   (req_ready),
    .duty_out    (duty_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int model_next(int cur, int tgt, int stp);
    int d;
    d = tgt - cur;
    if (stp == 0 || (d < 0 ? -d : d) <= stp) return tgt;
    return (d > 0) ? cur + stp : cur - stp;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int exp_duty, input logic exp_done);
    period_tick = 1'b1;
    step_cycle();
    period_tick = 1'b0;
    chk("tick_duty", duty_out, exp_duty);
    chk("tick_done", done, exp_done);
  endtask

  task automatic do_request(input int tgt, input int stp);
    int n;
    n = 0;
    while (!req_ready && n < 1000) begin
      step_cycle();
      n++;
    end
    chk("ready_wait", req_ready, 1);
    req_valid  = 1'b1;
    req_target = tgt[WIDTH-1:0];
    req_step   = stp[WIDTH-1:0];
    step_cycle();
    req_valid  = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_ready", req_ready, EXP_RAMP_READY);
    chk("accept_duty", duty_out, m_duty);
  endtask

  // Drives ticks separated by 'gap' idle cycles until the model reaches the
  // target, then checks the return to idle.
  task automatic run_ticks(input int tgt, input int stp, input int gap);
    int q[$];
    int cur;
    cur = m_duty;
    do begin
      cur = model_next(cur, tgt, stp);
      q.push_back(cur);
    end while (cur != tgt && q.size() < 300);
    foreach (q[i]) begin
      repeat (gap) step_cycle();
      if (gap > 0) begin
        chk("gap_hold", duty_out, m_duty);
        chk("gap_busy", busy, 1);
      end
      do_tick(q[i], q[i] == tgt);
      m_duty = q[i];
    end
    chk("done_busy", busy, 1);
    step_cycle();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_ready", req_ready, 1);
  endtask

  task automatic ramp(input int tgt, input int stp, input int gap);
    do_request(tgt, stp);
    run_ticks(tgt, stp, gap);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int tgt;
    int stp;
    vectors     = 0;
    miscompares = 0;
    m_duty      = 0;
    rst         = 1'b1;
    period_tick = 1'b0;
    req_valid   = 1'b0;
    req_target  = '0;
    req_step    = '0;

    // Reset state
    repeat (3) step_cycle();
    rst = 1'b0;
    chk("rst_duty", duty_out, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // 0 -> 100 step 30, ticks every 256 cycles: 30, 60, 90, 100
    ramp(100, 30, 255);

    // 100 -> 5 step 40: 60, 20, 5 (no underflow)
    ramp(5, 40, 2);

    // Request equal to current duty after going to 0: one tick, no change
    ramp(0, 0, 1);
    ramp(0, 7, 1);

    // step 0 jumps straight to 255 at the first tick
    ramp(255, 0, 3);
    ramp(0, 0, 0);

    // Accept coinciding with a tick in IDLE: that tick is ignored
    req_valid   = 1'b1;
    req_target  = 8'd10;
    req_step    = 8'd10;
    period_tick = 1'b1;
    step_cycle();
    req_valid   = 1'b0;
    period_tick = 1'b0;
    chk("coinc_duty", duty_out, 0);
    chk("coinc_busy", busy, 1);
    chk("coinc_done", done, 0);
    run_ticks(10, 10, 2);

    // Reset in the middle of a ramp at duty 60
    ramp(0, 0, 0);
    do_request(200, 30);
    do_tick(30, 1'b0);
    do_tick(60, 1'b0);
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    m_duty = 0;
    chk("midrst_duty", duty_out, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      do_tick(0, 1'b0);
      chk("midrst_idle", busy, 0);
    end

`ifdef PWM_RAMP_RETARGET_EN
    // Retarget while ramping 0 -> 200 step 50, at duty 100 ask for 120
    do_request(200, 50);
    do_tick(50, 1'b0);
    do_tick(100, 1'b0);
    chk("rt_ready", req_ready, 1);
    do_request(120, 50);
    run_ticks(120, 50, 1);

    // Retarget coinciding with a tick: the tick uses the old target/step
    do_request(0, 50);
    do_tick(70, 1'b0);
    req_valid   = 1'b1;
    req_target  = 8'd200;
    req_step    = 8'd10;
    period_tick = 1'b1;
    step_cycle();
    req_valid   = 1'b0;
    period_tick = 1'b0;
    chk("rt_coinc_duty", duty_out, 20);
    chk("rt_coinc_done", done, 0);
    chk("rt_coinc_busy", busy, 1);
    m_duty = 20;
    run_ticks(200, 10, 0);
`else
    // Without retarget a request during a ramp stalls until after done
    do_request(200, 50);
    do_tick(50, 1'b0);
    do_tick(100, 1'b0);
    req_valid  = 1'b1;
    req_target = 8'd120;
    req_step   = 8'd50;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", req_ready, 0);
      step_cycle();
      chk("stall_duty", duty_out, 100);
    end
    chk("stall_ready_t1", req_ready, 0);
    do_tick(150, 1'b0);
    chk("stall_ready_t2", req_ready, 0);
    do_tick(200, 1'b1);
    chk("stall_ready_done", req_ready, 0);
    step_cycle();
    chk("stall_ready_back", req_ready, 1);
    chk("stall_idle", busy, 0);
    step_cycle();
    req_valid = 1'b0;
    chk("stall_accepted", busy, 1);
    chk("stall_hold", duty_out, 200);
    m_duty = 200;
    run_ticks(120, 50, 1);
`endif

    // Randomized ramps, including boundary targets 0 and 255
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0:       tgt = 0;
        1:       tgt = 255;
        default: tgt = int'($urandom_range(0, 255));
      endcase
      stp = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(3, 255));
      ramp(tgt, stp, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
